// File: rtl/seven_seg_scan_if.sv
// Multiplexed 7-segment display bus plus the decoded-frame outputs of the scan decoder.
// The master drives the display lines; the slave recovers digits from them.
interface seven_seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg_n;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   digit_err;
    logic                    frame_valid;

    modport master (
        output seg_n,
        output dig_sel,
        input  value,
        input  digit_err,
        input  frame_valid
    );

    modport slave (
        input  seg_n,
        input  dig_sel,
        output value,
        output digit_err,
        output frame_valid
    );
endinterface

// File: rtl/seven_seg_scan_decoder.sv
// Recovers BCD digits from a multiplexed active-low 7-segment bus: each strobed digit must hold
// steady for STABLE_CYCLES samples before capture, and a word is published once every digit is seen.
module seven_seg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              resetn,
    seven_seg_scan_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [7:0]            STABLE_C = 8'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] ALL_ONES = {NUM_DIGITS{1'b1}};
    localparam logic [NUM_DIGITS-1:0] NONE     = {NUM_DIGITS{1'b0}};

    // Inverse of the binary-to-segment encoder; returns {err, nibble}.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'h40:   decode_seg = {1'b0, 4'd0};
            7'h79:   decode_seg = {1'b0, 4'd1};
            7'h24:   decode_seg = {1'b0, 4'd2};
            7'h30:   decode_seg = {1'b0, 4'd3};
            7'h19:   decode_seg = {1'b0, 4'd4};
            7'h12:   decode_seg = {1'b0, 4'd5};
            7'h02:   decode_seg = {1'b0, 4'd6};
            7'h78:   decode_seg = {1'b0, 4'd7};
            7'h00:   decode_seg = {1'b0, 4'd8};
            7'h10:   decode_seg = {1'b0, 4'd9};
            default: decode_seg = {1'b1, 4'd0};
        endcase
    endfunction

    logic [6:0]              s_seg_q, p_seg_q;
    logic [NUM_DIGITS-1:0]   s_sel_q, p_sel_q;
    logic [7:0]              cnt_q, cnt_d;
    state_t                  state_q, state_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [4*NUM_DIGITS-1:0] hold_val_q, hold_val_d;
    logic [NUM_DIGITS-1:0]   hold_err_q, hold_err_d;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   digit_err_q, digit_err_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    onehot_s, changed_s, capture_s;
    logic [4:0]              dec_s;

    // Input sampling, previous-sample copy and all state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_seg_q       <= 7'h00;
            s_sel_q       <= NONE;
            p_seg_q       <= 7'h00;
            p_sel_q       <= NONE;
            cnt_q         <= 8'd0;
            state_q       <= ST_IDLE;
            mask_q        <= NONE;
            hold_val_q    <= {(4*NUM_DIGITS){1'b0}};
            hold_err_q    <= NONE;
            value_q       <= {(4*NUM_DIGITS){1'b0}};
            digit_err_q   <= NONE;
            frame_valid_q <= 1'b0;
        end else begin
            s_seg_q       <= bus.seg_n;
            s_sel_q       <= bus.dig_sel;
            p_seg_q       <= s_seg_q;
            p_sel_q       <= s_sel_q;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            mask_q        <= mask_d;
            hold_val_q    <= hold_val_d;
            hold_err_q    <= hold_err_d;
            value_q       <= value_d;
            digit_err_q   <= digit_err_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    // Stability counter and scan FSM; a capture fires on the edge the counter reaches STABLE_C.
    always_comb begin
        onehot_s  = $onehot(s_sel_q);
        changed_s = (s_seg_q != p_seg_q) || (s_sel_q != p_sel_q);
        state_d   = state_q;
        capture_s = 1'b0;

        if (!onehot_s) begin
            cnt_d = 8'd0;
        end else if (changed_s) begin
            cnt_d = 8'd1;
        end else if (cnt_q < STABLE_C) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            ST_IDLE, ST_SETTLE: begin
                if (!onehot_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_d == STABLE_C) begin
                    state_d   = ST_CAPTURE;
                    capture_s = 1'b1;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_CAPTURE, ST_DONE: begin
                if (!onehot_s) begin
                    state_d = ST_IDLE;
                end else if (changed_s) begin
                    // With a one-sample filter a change is already stable enough to capture.
                    if (cnt_d == STABLE_C) begin
                        state_d   = ST_CAPTURE;
                        capture_s = 1'b1;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Holding registers, capture mask and frame publication.
    always_comb begin
        dec_s         = decode_seg(s_seg_q);
        hold_val_d    = hold_val_q;
        hold_err_d    = hold_err_q;
        mask_d        = mask_q;
        value_d       = value_q;
        digit_err_d   = digit_err_q;
        frame_valid_d = 1'b0;

        if (capture_s) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (s_sel_q[i]) begin
                    hold_val_d[4*i +: 4] = dec_s[3:0];
                    hold_err_d[i]        = dec_s[4];
                end else begin
                    hold_val_d[4*i +: 4] = hold_val_q[4*i +: 4];
                    hold_err_d[i]        = hold_err_q[i];
                end
            end
            mask_d = mask_q | s_sel_q;
            if (mask_d == ALL_ONES) begin
                value_d       = hold_val_d;
                digit_err_d   = hold_err_d;
                frame_valid_d = 1'b1;
                mask_d        = NONE;
            end else begin
                frame_valid_d = 1'b0;
            end
        end else begin
            frame_valid_d = 1'b0;
        end
    end

    assign bus.value       = value_q;
    assign bus.digit_err   = digit_err_q;
    assign bus.frame_valid = frame_valid_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Scoreboard bench: two decoders (filter depth 4 and 1) watch the same display bus; a run-level
// model predicts published frames, and per-instance monitors pop and compare on each frame_valid.
module tb_seven_seg_scan_decoder;

    localparam int ND  = 2;
    localparam int ST0 = 4;
    localparam int ST1 = 1;
    localparam logic [6:0] PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct packed {
        logic [4*ND-1:0] v;
        logic [ND-1:0]   e;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    seven_seg_scan_if #(.NUM_DIGITS(ND)) bus0 ();
    seven_seg_scan_if #(.NUM_DIGITS(ND)) bus1 ();
    assign bus1.seg_n   = bus0.seg_n;
    assign bus1.dig_sel = bus0.dig_sel;

    seven_seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(ST0)) dut0 (
        .clk(clk), .resetn(resetn), .bus(bus0));
    seven_seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(ST1)) dut1 (
        .clk(clk), .resetn(resetn), .bus(bus1));

    int checks   = 0;
    int failures = 0;
    exp_t exp0[$];
    exp_t exp1[$];
    exp_t last_exp[2];
    logic [3:0]    mh_val [2][ND];
    logic          mh_err [2][ND];
    logic [ND-1:0] m_mask [2];
    logic [ND-1:0] prev_sel;
    logic [6:0]    prev_seg;

    function automatic int stable_of(int k);
        return (k == 0) ? ST0 : ST1;
    endfunction

    // Record one captured digit in instance k's model; publish when every digit has been seen.
    task automatic model_capture(int k, logic [ND-1:0] sel, logic [6:0] seg);
        int d;
        logic [3:0] n;
        logic e;
        exp_t x;
        d = 0;
        for (int i = 0; i < ND; i++) if (sel[i]) d = i;
        n = 4'd0;
        e = 1'b1;
        for (int p = 0; p < 10; p++) if (PAT[p] == seg) begin n = 4'(p); e = 1'b0; end
        mh_val[k][d] = n;
        mh_err[k][d] = e;
        m_mask[k]    = m_mask[k] | sel;
        if (m_mask[k] == {ND{1'b1}}) begin
            for (int i = 0; i < ND; i++) begin
                x.v[4*i +: 4] = mh_val[k][i];
                x.e[i]        = mh_err[k][i];
            end
            if (k == 0) exp0.push_back(x); else exp1.push_back(x);
            last_exp[k] = x;
            m_mask[k]   = {ND{1'b0}};
        end
    endtask

    // Hold one bus pattern for len cycles; a one-hot run lasting at least the filter depth is captured.
    task automatic run(logic [ND-1:0] sel, logic [6:0] seg, int len);
        logic [6:0] s;
        s = seg;
        if (sel == prev_sel && s == prev_seg) s = s ^ 7'h01;
        bus0.dig_sel = sel;
        bus0.seg_n   = s;
        prev_sel     = sel;
        prev_seg     = s;
        for (int k = 0; k < 2; k++)
            if ($onehot(sel) && len >= stable_of(k)) model_capture(k, sel, s);
        repeat (len) @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [4*ND-1:0] av, logic [ND-1:0] ae,
                         logic [4*ND-1:0] ev, logic [ND-1:0] ee);
        checks++;
        if (av !== ev || ae !== ee) begin
            failures++;
            $display("FAIL %s: value=%h err=%b, expected value=%h err=%b", name, av, ae, ev, ee);
        end
    endtask

    task automatic apply_reset();
        run({ND{1'b0}}, 7'h7F, 3);
        resetn = 1'b0;
        m_mask[0] = {ND{1'b0}};
        m_mask[1] = {ND{1'b0}};
        last_exp[0] = '0;
        last_exp[1] = '0;
        @(posedge clk);
        #1;
        check("reset0", bus0.value, bus0.digit_err, 8'h00, 2'b00);
        check("reset1", bus1.value, bus1.digit_err, 8'h00, 2'b00);
        resetn   = 1'b1;
        prev_sel = {ND{1'b0}};
        prev_seg = 7'h00;
    endtask

    // Scoreboard monitor for the depth-4 decoder.
    always @(negedge clk) begin
        exp_t x;
        if (resetn && bus0.frame_valid) begin
            checks++;
            if (exp0.size() == 0) begin
                failures++;
                $display("FAIL frame0_unexpected: value=%h err=%b, expected no frame", bus0.value, bus0.digit_err);
            end else begin
                x = exp0.pop_front();
                if (bus0.value !== x.v || bus0.digit_err !== x.e) begin
                    failures++;
                    $display("FAIL frame0: value=%h err=%b, expected value=%h err=%b", bus0.value, bus0.digit_err, x.v, x.e);
                end
            end
        end
    end

    // Scoreboard monitor for the depth-1 decoder.
    always @(negedge clk) begin
        exp_t x;
        if (resetn && bus1.frame_valid) begin
            checks++;
            if (exp1.size() == 0) begin
                failures++;
                $display("FAIL frame1_unexpected: value=%h err=%b, expected no frame", bus1.value, bus1.digit_err);
            end else begin
                x = exp1.pop_front();
                if (bus1.value !== x.v || bus1.digit_err !== x.e) begin
                    failures++;
                    $display("FAIL frame1: value=%h err=%b, expected value=%h err=%b", bus1.value, bus1.digit_err, x.v, x.e);
                end
            end
        end
    end

    initial begin
        logic [ND-1:0] sel;
        logic [6:0]    seg;
        int            r;

        resetn       = 1'b0;
        bus0.seg_n   = 7'h7F;
        bus0.dig_sel = {ND{1'b0}};
        prev_sel     = {ND{1'b0}};
        prev_seg     = 7'h7F;
        m_mask[0]    = {ND{1'b0}};
        m_mask[1]    = {ND{1'b0}};
        last_exp[0]  = '0;
        last_exp[1]  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("por0", bus0.value, bus0.digit_err, 8'h00, 2'b00);
        check("por1", bus1.value, bus1.digit_err, 8'h00, 2'b00);
        checks++;
        if (bus0.frame_valid !== 1'b0 || bus1.frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL por_fv: frame_valid=%b%b, expected 00", bus1.frame_valid, bus0.frame_valid);
        end
        resetn   = 1'b1;
        prev_sel = {ND{1'b0}};
        prev_seg = 7'h00;

        // Basic two-digit frame.
        run(2'b01, 7'h30, 6); run(2'b10, 7'h12, 6); run(2'b00, 7'h7F, 3);
        check("basic", bus0.value, bus0.digit_err, 8'h53, 2'b00);
        // Glitch shorter than the filter is ignored.
        run(2'b01, 7'h19, 3); run(2'b01, 7'h79, 5); run(2'b10, 7'h00, 5); run(2'b00, 7'h7F, 3);
        check("glitch", bus0.value, bus0.digit_err, 8'h81, 2'b00);
        // Blank pattern flags an error.
        run(2'b01, 7'h7F, 5); run(2'b10, 7'h40, 5); run(2'b00, 7'h7F, 3);
        check("invalid", bus0.value, bus0.digit_err, 8'h00, 2'b01);
        // Multi-hot select never captures; next frame decodes normally.
        run(2'b11, 7'h24, 10); run(2'b01, 7'h02, 5); run(2'b10, 7'h78, 5); run(2'b00, 7'h7F, 3);
        check("multihot", bus0.value, bus0.digit_err, 8'h76, 2'b00);
        // Reset mid-frame drops the partial capture.
        apply_reset();
        run(2'b01, 7'h02, 5);
        apply_reset();
        run(2'b10, 7'h12, 5); run(2'b00, 7'h7F, 3);
        check("midreset0", bus0.value, bus0.digit_err, 8'h00, 2'b00);
        check("midreset1", bus1.value, bus1.digit_err, 8'h00, 2'b00);
        // Recapture overwrites digit0 before the frame completes.
        run(2'b01, 7'h02, 5); run(2'b01, 7'h10, 5); run(2'b10, 7'h78, 5); run(2'b00, 7'h7F, 3);
        check("recapture", bus0.value, bus0.digit_err, 8'h79, 2'b00);
        // One-cycle holds: only the depth-1 decoder captures.
        run(2'b01, 7'h30, 1); run(2'b10, 7'h12, 1); run(2'b00, 7'h7F, 3);
        check("depth1_fast", bus1.value, bus1.digit_err, 8'h53, 2'b00);
        check("depth4_hold", bus0.value, bus0.digit_err, 8'h79, 2'b00);
        // Hold of exactly the filter depth captures; one less does not.
        run(2'b01, 7'h40, 4); run(2'b10, 7'h79, 4); run(2'b00, 7'h7F, 3);
        check("exact_depth", bus0.value, bus0.digit_err, 8'h10, 2'b00);
        run(2'b01, 7'h24, 3); run(2'b10, 7'h30, 3); run(2'b00, 7'h7F, 3);
        check("short_depth", bus0.value, bus0.digit_err, 8'h10, 2'b00);
        check("short_depth1", bus1.value, bus1.digit_err, 8'h32, 2'b00);

        // Randomized runs.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7) sel = ND'(1 << $urandom_range(0, ND - 1));
            else if (r == 7) sel = {ND{1'b0}};
            else sel = {ND{1'b1}};
            if ($urandom_range(0, 4) == 0) seg = 7'($urandom);
            else seg = PAT[$urandom_range(0, 9)];
            run(sel, seg, $urandom_range(1, 7));
            if ($urandom_range(0, 79) == 0) apply_reset();
        end
        run(2'b00, 7'h7F, 10);

        checks++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            failures++;
            $display("FAIL pending_frames: left=%0d/%0d, expected 0/0", exp0.size(), exp1.size());
        end
        check("final0", bus0.value, bus0.digit_err, last_exp[0].v, last_exp[0].e);
        check("final1", bus1.value, bus1.digit_err, last_exp[1].v, last_exp[1].e);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
